// File: rtl/alu_arbiter_if.sv
// Request/ALU/response bundle between two requesters, the arbiter and a shared ALU.
//   req_*   : requester -> arbiter command channel (packed, 2 requesters)
//   alu_*   : arbiter <-> shared ALU operand/result lines
//   rsp_*   : arbiter -> requester response channel
//   busy    : arbiter has a transaction in flight
// slave modport is the arbiter's view, master modport the requester/ALU side.
interface alu_arbiter_if;
  localparam int unsigned N_REQ = 2;
  localparam int unsigned CMD_W = 5;
  localparam int unsigned OP_W  = 4;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ*OP_W-1:0]  req_a;
  logic [N_REQ*OP_W-1:0]  req_b;
  logic [CMD_W-1:0]       alu_cmd;
  logic [OP_W-1:0]        alu_a;
  logic [OP_W-1:0]        alu_b;
  logic [OP_W-1:0]        alu_result;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ack;
  logic [OP_W-1:0]        rsp_data;
  logic                   rsp_err;
  logic                   busy;

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, alu_result, rsp_ack,
    output req_ready, alu_cmd, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_cmd, req_a, req_b, alu_result, rsp_ack,
    input  req_ready, alu_cmd, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : alu_arbiter_if.slave (request, ALU and response channels)
// Parameter WAIT_CYCLES (>=1): cycles the ALU inputs are held before sampling alu_result.
module alu_arbiter #(
  parameter int unsigned WAIT_CYCLES = 32'd1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  alu_arbiter_if.slave  bus
);
  localparam int unsigned CMD_W = 5;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 32;

  // Function codes of the shared ALU
  localparam logic [CMD_W-1:0] F_ADD = 5'h00;
  localparam logic [CMD_W-1:0] F_SUB = 5'h01;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] alu_cmd_q, alu_cmd_d;
  logic [OP_W-1:0]  alu_a_q, alu_a_d;
  logic [OP_W-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]  rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic             gnt_any;
  logic             gnt_sel;
  logic             transfer;
  logic [CMD_W-1:0] sel_cmd;
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;

  // Arbitration: single requester wins outright, contention goes to the one not served last
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    case (bus.req_valid)
      2'b01:   begin gnt_any = 1'b1; gnt_sel = 1'b0;          end
      2'b10:   begin gnt_any = 1'b1; gnt_sel = 1'b1;          end
      2'b11:   begin gnt_any = 1'b1; gnt_sel = ~last_grant_q; end
      default: begin gnt_any = 1'b0; gnt_sel = 1'b0;          end
    endcase
  end

  // Ready is gated by reset so nothing is offered while the block is held in reset
  always_comb begin
    bus.req_ready = 2'b00;
    if (sys_rst_n && (state_q == IDLE) && gnt_any) begin
      bus.req_ready = gnt_sel ? 2'b10 : 2'b01;
    end
  end

  assign transfer = (state_q == IDLE) && gnt_any;
  assign sel_cmd  = gnt_sel ? bus.req_cmd[9:5] : bus.req_cmd[4:0];
  assign sel_a    = gnt_sel ? bus.req_a[7:4]   : bus.req_a[3:0];
  assign sel_b    = gnt_sel ? bus.req_b[7:4]   : bus.req_b[3:0];

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    alu_cmd_d    = alu_cmd_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          grant_d = gnt_sel;
          busy_d  = 1'b1;
          if ((sel_cmd == F_ADD) || (sel_cmd == F_SUB)) begin
            alu_cmd_d = sel_cmd;
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            cnt_d     = CNT_W'(WAIT_CYCLES - 32'd1);
            state_d   = ISSUE;
          end else begin
            // Unsupported command: answer with an error, ALU lines untouched
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = {gnt_sel, ~gnt_sel};
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d  = bus.alu_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = {grant_q, ~grant_q};
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Only the granted requester's ack closes the transaction
        if (bus.rsp_ack[grant_q]) begin
          last_grant_d = grant_q;
          rsp_valid_d  = 2'b00;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 2'b00;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      alu_cmd_q    <= F_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      alu_cmd_q    <= alu_cmd_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with WAIT_CYCLES=1, one with 4,
// each wired to a behavioural ALU.
module tb_alu_arbiter;
  localparam logic [4:0] F_ADD = 5'h00;
  localparam logic [4:0] F_SUB = 5'h01;
  localparam logic [4:0] F_BAD = 5'h1F;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if b1();
  alu_arbiter_if b4();

  alu_arbiter #(.WAIT_CYCLES(32'd1)) dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));
  alu_arbiter #(.WAIT_CYCLES(32'd4)) dut4 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b4));

  function automatic logic [3:0] alu_model(input logic [4:0] c, input logic [3:0] a,
                                           input logic [3:0] b);
    case (c)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      default: return 4'h0;
    endcase
  endfunction

  assign b1.alu_result = alu_model(b1.alu_cmd, b1.alu_a, b1.alu_b);
  assign b4.alu_result = alu_model(b4.alu_cmd, b4.alu_a, b4.alu_b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.req_valid = 2'b11;
    #2;
    n_cmp++; if (b1.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", b1.req_ready); end
    n_cmp++; if (b1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", b1.busy); end
    n_cmp++; if (b1.rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", b1.rsp_valid); end
    n_cmp++; if (b1.alu_cmd !== F_ADD) begin n_err++; $display("FAIL reset_alu_cmd got=%h exp=%h", b1.alu_cmd, F_ADD); end
    n_cmp++; if ({b1.alu_a, b1.alu_b, b1.rsp_data, b1.rsp_err} !== 13'd0) begin
      n_err++; $display("FAIL reset_data got=%h/%h/%h/%b exp=0", b1.alu_a, b1.alu_b, b1.rsp_data, b1.rsp_err); end
    b1.req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    b1.req_cmd = {F_ADD, F_ADD};
    b1.req_a = 8'h03; b1.req_b = 8'h04;
    b1.req_valid = 2'b01;
    #1;
    n_cmp++; if (b1.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got=%b exp=01", b1.req_ready); end
    step();
    b1.req_valid = 2'b00;
    #1;
    n_cmp++; if ({b1.busy, b1.rsp_valid, b1.req_ready} !== 5'b1_00_00) begin
      n_err++; $display("FAIL single_issue busy/vld/rdy got=%b/%b/%b exp=1/00/00", b1.busy, b1.rsp_valid, b1.req_ready); end
    n_cmp++; if ({b1.alu_cmd, b1.alu_a, b1.alu_b} !== {F_ADD, 4'd3, 4'd4}) begin
      n_err++; $display("FAIL single_alu got=%h/%h/%h exp=%h/3/4", b1.alu_cmd, b1.alu_a, b1.alu_b, F_ADD); end
    step();
    n_cmp++; if ({b1.rsp_valid, b1.rsp_data, b1.rsp_err} !== {2'b01, 4'd7, 1'b0}) begin
      n_err++; $display("FAIL single_rsp got=%b/%h/%b exp=01/7/0", b1.rsp_valid, b1.rsp_data, b1.rsp_err); end
    b1.rsp_ack = 2'b01;
    step();
    b1.rsp_ack = 2'b00;
    n_cmp++; if ({b1.busy, b1.rsp_valid} !== 3'b0_00) begin
      n_err++; $display("FAIL single_ack busy/vld got=%b/%b exp=0/00", b1.busy, b1.rsp_valid); end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    b1.req_cmd = {F_SUB, F_ADD};
    b1.req_a = {4'd9, 4'd2}; b1.req_b = {4'd5, 4'd2};
    b1.req_valid = 2'b11;
    #1;
    n_cmp++; if (b1.req_ready !== 2'b01) begin n_err++; $display("FAIL cont_first_ready got=%b exp=01", b1.req_ready); end
    step();
    step();
    n_cmp++; if ({b1.rsp_valid, b1.rsp_data, b1.req_ready} !== {2'b01, 4'd4, 2'b00}) begin
      n_err++; $display("FAIL cont_rsp0 got=%b/%h/%b exp=01/4/00", b1.rsp_valid, b1.rsp_data, b1.req_ready); end
    b1.rsp_ack = 2'b11;
    step();
    b1.rsp_ack = 2'b00;
    n_cmp++; if ({b1.busy, b1.req_ready} !== 3'b0_10) begin
      n_err++; $display("FAIL cont_rr_ready busy/rdy got=%b/%b exp=0/10", b1.busy, b1.req_ready); end
    step();
    step();
    n_cmp++; if ({b1.rsp_valid, b1.rsp_data, b1.rsp_err} !== {2'b10, 4'd4, 1'b0}) begin
      n_err++; $display("FAIL cont_rsp1 got=%b/%h/%b exp=10/4/0", b1.rsp_valid, b1.rsp_data, b1.rsp_err); end
    b1.rsp_ack = 2'b10;
    step();
    b1.rsp_ack = 2'b00;
    n_cmp++; if (b1.req_ready !== 2'b01) begin n_err++; $display("FAIL cont_back_to_0 got=%b exp=01", b1.req_ready); end
    b1.req_valid = 2'b00;
  endtask

  task automatic test_bad_cmd();
    b1.req_cmd = {F_BAD, F_ADD};
    b1.req_a = 8'hEE; b1.req_b = 8'hDD;
    b1.req_valid = 2'b10;
    #1;
    n_cmp++; if (b1.req_ready !== 2'b10) begin n_err++; $display("FAIL bad_ready got=%b exp=10", b1.req_ready); end
    step();
    b1.req_valid = 2'b00;
    n_cmp++; if ({b1.busy, b1.rsp_valid, b1.rsp_data, b1.rsp_err} !== {1'b1, 2'b10, 4'd0, 1'b1}) begin
      n_err++; $display("FAIL bad_rsp got=%b/%b/%h/%b exp=1/10/0/1", b1.busy, b1.rsp_valid, b1.rsp_data, b1.rsp_err); end
    n_cmp++; if ({b1.alu_cmd, b1.alu_a, b1.alu_b} !== {F_SUB, 4'd9, 4'd5}) begin
      n_err++; $display("FAIL bad_alu_kept got=%h/%h/%h exp=%h/9/5", b1.alu_cmd, b1.alu_a, b1.alu_b, F_SUB); end
    b1.rsp_ack = 2'b10;
    step();
    b1.rsp_ack = 2'b00;
    n_cmp++; if (b1.busy !== 1'b0) begin n_err++; $display("FAIL bad_ack busy got=%b exp=0", b1.busy); end
  endtask

  task automatic test_latency_hold();
    logic [1:0] exp_v;
    b4.req_cmd = {F_ADD, F_SUB};
    b4.req_a = 8'h00; b4.req_b = 8'h01;
    b4.req_valid = 2'b01;
    #1;
    n_cmp++; if (b4.req_ready !== 2'b01) begin n_err++; $display("FAIL lat_ready got=%b exp=01", b4.req_ready); end
    step();
    b4.req_valid = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = (k == 4) ? 2'b01 : 2'b00;
      n_cmp++; if (b4.rsp_valid !== exp_v) begin
        n_err++; $display("FAIL lat_cycle%0d rsp_valid got=%b exp=%b", k, b4.rsp_valid, exp_v); end
    end
    n_cmp++; if ({b4.rsp_data, b4.rsp_err} !== {4'hF, 1'b0}) begin
      n_err++; $display("FAIL lat_data got=%h/%b exp=f/0", b4.rsp_data, b4.rsp_err); end
    b4.rsp_ack = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if ({b4.busy, b4.rsp_valid, b4.rsp_data, b4.rsp_err} !== {1'b1, 2'b01, 4'hF, 1'b0}) begin
        n_err++; $display("FAIL hold_cycle%0d got=%b/%b/%h/%b exp=1/01/f/0", k, b4.busy, b4.rsp_valid, b4.rsp_data, b4.rsp_err); end
    end
    b4.rsp_ack = 2'b01;
    step();
    b4.rsp_ack = 2'b00;
    n_cmp++; if ({b4.busy, b4.rsp_valid} !== 3'b0_00) begin
      n_err++; $display("FAIL hold_ack got=%b/%b exp=0/00", b4.busy, b4.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    b4.req_cmd = {F_ADD, F_ADD};
    b4.req_a = {4'd5, 4'd1}; b4.req_b = {4'd6, 4'd2};
    b4.req_valid = 2'b10;
    step();
    b4.req_valid = 2'b00;
    step();
    n_cmp++; if ({b4.busy, b4.alu_a} !== {1'b1, 4'd5}) begin
      n_err++; $display("FAIL mid_pre busy/alu_a got=%b/%h exp=1/5", b4.busy, b4.alu_a); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({b4.busy, b4.rsp_valid, b4.rsp_data, b4.rsp_err} !== 8'd0) begin
      n_err++; $display("FAIL mid_rst_rsp got=%b/%b/%h/%b exp=0/00/0/0", b4.busy, b4.rsp_valid, b4.rsp_data, b4.rsp_err); end
    n_cmp++; if ({b4.alu_cmd, b4.alu_a, b4.alu_b} !== {F_ADD, 8'd0}) begin
      n_err++; $display("FAIL mid_rst_alu got=%h/%h/%h exp=%h/0/0", b4.alu_cmd, b4.alu_a, b4.alu_b, F_ADD); end
    b4.req_valid = 2'b11;
    #1;
    n_cmp++; if (b4.req_ready !== 2'b00) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=00", b4.req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (b4.req_ready !== 2'b01) begin n_err++; $display("FAIL mid_after_ready got=%b exp=01", b4.req_ready); end
    step();
    b4.req_valid = 2'b00;
    n_cmp++; if ({b4.busy, b4.alu_a, b4.alu_b} !== {1'b1, 4'd1, 4'd2}) begin
      n_err++; $display("FAIL mid_after_grant got=%b/%h/%h exp=1/1/2", b4.busy, b4.alu_a, b4.alu_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    b1.req_valid = 2'b00; b1.req_cmd = '0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ack = 2'b00;
    b4.req_valid = 2'b00; b4.req_cmd = '0; b4.req_a = '0; b4.req_b = '0; b4.rsp_ack = 2'b00;
    test_reset();
    test_single();
    test_contention();
    test_bad_cmd();
    test_latency_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
